imm_extend_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Takes a 32-bit RV instruction plus a 3-bit immediate-format select and produces a sign- or zero-extended immediate of D_WIDTH bits. Adds valid/ready handshaking, a 2-entry skid buffer, a synchronous flush for redirects, and a saturating illegal-format counter. It sits between fetch/decode and the register-read/execute stage.

---
 rtl/imm_extend_pipe.sv | 193 +++++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Decode-stage immediate generator. Builds a sign/zero-extended
//            immediate of D_WIDTH bits from a 32-bit RV instruction and a
//            3-bit format select. The result is carried with a sideband tag
//            through a valid/ready pipeline stage backed by a skid register.
//            The stage also provides a synchronous flush and a saturating
//            illegal-format counter.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            flush           - synchronous discard of all buffered entries
//            in_valid/in_ready, instr, immsrc, in_tag - input handshake
//            out_valid/out_ready, immext, out_tag, out_err - output handshake
//            err_count       - illegal-immsrc accepts, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int D_WIDTH   = 32,
    parameter int TAG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [2:0]           immsrc,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_WIDTH-1:0]   immext,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_err,
    output logic [7:0]           err_count
);

    localparam logic [2:0] c_SRC_I  = 3'b000;
    localparam logic [2:0] c_SRC_S  = 3'b001;
    localparam logic [2:0] c_SRC_B  = 3'b010;
    localparam logic [2:0] c_SRC_J  = 3'b011;
    localparam logic [2:0] c_SRC_U  = 3'b100;
    localparam logic [2:0] c_SRC_Z  = 3'b101;
    localparam logic [2:0] c_SRC_SH = 3'b110;
    localparam logic [7:0] c_ERR_MAX = 8'd255;

    generate
        if (D_WIDTH != 32 && D_WIDTH != 64) begin : g_bad_width
            $error("imm_extend_pipe: D_WIDTH must be 32 or 64");
        end
    endgenerate

    // Opcode bits play no part in immediate extraction.
    logic w_unused_opcode;
    assign w_unused_opcode = ^instr[6:0];

    // ------------------------------------------------------------------
    // Immediate extraction. Sign-extended formats start from a word filled
    // with instr[31] and then overwrite the low field; zero-extended ones
    // start from zero.
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0] w_imm;
    logic               w_illegal;

    always_comb begin
        w_imm     = {D_WIDTH{instr[31]}};
        w_illegal = 1'b0;
        case (immsrc)
            c_SRC_I:  w_imm[11:0] = instr[31:20];
            c_SRC_S:  w_imm[11:0] = {instr[31:25], instr[11:7]};
            c_SRC_B:  w_imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            c_SRC_J:  w_imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            c_SRC_U:  w_imm[31:0] = {instr[31:12], 12'b0};
            c_SRC_Z: begin
                w_imm      = '0;
                w_imm[4:0] = instr[19:15];
            end
            c_SRC_SH: begin
                // Shift amount is 6 bits wide on a 64-bit datapath.
                w_imm = '0;
                if (D_WIDTH == 64) begin
                    w_imm[5:0] = instr[25:20];
                end else begin
                    w_imm[4:0] = instr[24:20];
                end
            end
            default: begin
                w_imm     = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: main entry drives the outputs, skid entry absorbs the one
    // extra accept that can happen while in_ready is still registered high.
    // ------------------------------------------------------------------
    logic                 main_valid_q, main_valid_d;
    logic [D_WIDTH-1:0]   main_imm_q,   main_imm_d;
    logic [TAG_WIDTH-1:0] main_tag_q,   main_tag_d;
    logic                 main_err_q,   main_err_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [D_WIDTH-1:0]   skid_imm_q,   skid_imm_d;
    logic [TAG_WIDTH-1:0] skid_tag_q,   skid_tag_d;
    logic                 skid_err_q,   skid_err_d;
    logic [7:0]           err_count_q,  err_count_d;

    logic w_accept;
    logic w_pop;

    assign w_accept = in_valid & ~skid_valid_q;
    assign w_pop    = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        err_count_d  = err_count_q;

        // Counting happens at accept, independent of a concurrent flush.
        if (w_accept && w_illegal && (err_count_q != c_ERR_MAX)) begin
            err_count_d = err_count_q + 8'd1;
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || w_pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                main_err_d   = skid_err_q;
                skid_valid_d = w_accept;
                if (w_accept) begin
                    skid_imm_d = w_imm;
                    skid_tag_d = in_tag;
                    skid_err_d = w_illegal;
                end
            end else begin
                main_valid_d = w_accept;
                if (w_accept) begin
                    main_imm_d = w_imm;
                    main_tag_d = in_tag;
                    main_err_d = w_illegal;
                end
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = w_imm;
            skid_tag_d   = in_tag;
            skid_err_d   = w_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            err_count_q  <= err_count_d;
        end
    end

    // in_ready comes straight from a flop, so it lags the skid by one cycle.
    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign immext    = main_imm_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Self-checking bench for imm_extend_pipe. Drives a 32-bit and a
//            64-bit instance with identical stimulus. Both are compared
//            against a queue-based reference model and against the literal
//            values of the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] immext32, out_tag32;
    logic [7:0]  err_count32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] immext64;
    logic [31:0] out_tag64;
    logic [7:0]  err_count64;

    imm_extend_pipe #(.D_WIDTH(32), .TAG_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .immext(immext32), .out_tag(out_tag32), .out_err(out_err32),
        .err_count(err_count32)
    );

    imm_extend_pipe #(.D_WIDTH(64), .TAG_WIDTH(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .immext(immext64), .out_tag(out_tag64), .out_err(out_err64),
        .err_count(err_count64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the stage behaves as a 2-deep FIFO whose head is the
    // output entry; acceptance is allowed whenever fewer than 2 are held.
    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [31:0] tag;
        logic        err;
    } ent_t;

    ent_t mq[$];
    int   m_err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                            input int width);
        logic signed [63:0] v;
        case (sel)
            3'd0: v = 64'($signed(ins[31:20]));
            3'd1: v = 64'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd4: v = 64'($signed(ins[31:12])) * 64'sd4096;
            3'd5: v = 64'(ins[19:15]);
            3'd6: v = (width == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
            default: v = '0;
        endcase
        if (width == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic check_outputs();
        logic exp_rdy;
        logic exp_vld;
        exp_rdy = (mq.size() < 2);
        exp_vld = (mq.size() > 0);
        chk("in_ready32", 64'(in_ready32), 64'(exp_rdy));
        chk("in_ready64", 64'(in_ready64), 64'(exp_rdy));
        chk("out_valid32", 64'(out_valid32), 64'(exp_vld));
        chk("out_valid64", 64'(out_valid64), 64'(exp_vld));
        if (exp_vld) begin
            chk("immext32", 64'(immext32), 64'(mq[0].imm32));
            chk("immext64", immext64, mq[0].imm64);
            chk("out_tag32", 64'(out_tag32), 64'(mq[0].tag));
            chk("out_tag64", 64'(out_tag64), 64'(mq[0].tag));
            chk("out_err32", 64'(out_err32), 64'(mq[0].err));
            chk("out_err64", 64'(out_err64), 64'(mq[0].err));
        end
        chk("err_count32", 64'(err_count32), 64'(m_err_cnt));
        chk("err_count64", 64'(err_count64), 64'(m_err_cnt));
    endtask

    task automatic model_step();
        logic acc, pop;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        pop = (mq.size() > 0) && out_ready;
        if (acc && immsrc == 3'b111 && m_err_cnt < 255) m_err_cnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) e = mq.pop_front();
            if (acc) begin
                e.imm64 = ref_imm(instr, immsrc, 64);
                e.imm32 = 32'(ref_imm(instr, immsrc, 32));
                e.tag   = in_tag;
                e.err   = (immsrc == 3'b111);
                mq.push_back(e);
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising
    // edge, return just after it.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid32"}, 64'(out_valid32), 64'd0);
        chk({tag, "_out_valid64"}, 64'(out_valid64), 64'd0);
        chk({tag, "_immext32"}, 64'(immext32), 64'd0);
        chk({tag, "_immext64"}, immext64, 64'd0);
        chk({tag, "_out_tag32"}, 64'(out_tag32), 64'd0);
        chk({tag, "_out_err32"}, 64'(out_err32), 64'd0);
        chk({tag, "_err_count32"}, 64'(err_count32), 64'd0);
        chk({tag, "_err_count64"}, 64'(err_count64), 64'd0);
        chk({tag, "_in_ready32"}, 64'(in_ready32), 64'd1);
        chk({tag, "_in_ready64"}, 64'(in_ready64), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int acc_cnt;
        int ill_acc;
        logic acc;
        logic [31:0] obs[$];

        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; immsrc = '0;
        in_tag = '0; out_ready = 1'b0;
        #1;
        check_reset_values("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_held");
        rst = 1'b0;

        // ---------------- I-type ----------------
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'hFFF0_0093; immsrc = 3'b000; in_tag = 32'h100;
        cycle();
        in_valid = 1'b0;
        chk("itype_valid", 64'(out_valid32), 64'd1);
        chk("itype_imm32", 64'(immext32), 64'hFFFF_FFFF);
        chk("itype_imm64", immext64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("itype_err", 64'(out_err32), 64'd0);
        cycle();

        // ---------------- B then J back-to-back ----------------
        in_valid = 1'b1; instr = 32'hFE00_0EE3; immsrc = 3'b010; in_tag = 32'h201;
        cycle();
        instr = 32'h0080_006F; immsrc = 3'b011; in_tag = 32'h202;
        chk("btype_imm32", 64'(immext32), 64'hFFFF_FFFC);
        chk("btype_tag", 64'(out_tag32), 64'h201);
        cycle();
        in_valid = 1'b0;
        chk("jtype_imm32", 64'(immext32), 64'h8);
        chk("jtype_tag", 64'(out_tag32), 64'h202);
        chk("jtype_valid", 64'(out_valid32), 64'd1);
        cycle();

        // ---------------- U and SH ----------------
        in_valid = 1'b1; instr = 32'h8000_00B7; immsrc = 3'b100; in_tag = 32'h300;
        cycle();
        instr = 32'h03F0_D093; immsrc = 3'b110; in_tag = 32'h301;
        chk("utype_imm64", immext64, 64'hFFFF_FFFF_8000_0000);
        chk("utype_imm32", 64'(immext32), 64'h8000_0000);
        cycle();
        in_valid = 1'b0;
        chk("sh_imm64", immext64, 64'h3F);
        chk("sh_imm32", 64'(immext32), 64'h1F);
        cycle();

        // ---------------- backpressure ----------------
        out_ready = 1'b0; t = 1; acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_tag = 32'(t); immsrc = 3'b000; instr = $urandom;
            acc = (mq.size() < 2);
            cycle();
            if (acc) begin
                t++;
                acc_cnt++;
            end
        end
        chk("bp_accepts", 64'(acc_cnt), 64'd2);
        chk("bp_in_ready", 64'(in_ready32), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && obs.size() < 5; i++) begin
            in_valid = (t <= 5); in_tag = 32'(t); instr = $urandom;
            if (out_valid32) obs.push_back(out_tag32);
            acc = in_valid && (mq.size() < 2);
            cycle();
            if (acc) t++;
        end
        in_valid = 1'b0;
        chk("bp_drain_count", 64'(obs.size()), 64'd5);
        for (int i = 0; i < obs.size(); i++) chk("bp_order", 64'(obs[i]), 64'(i + 1));

        // ---------------- flush with main and skid full ----------------
        out_ready = 1'b0; in_valid = 1'b1; immsrc = 3'b001;
        in_tag = 32'h401; instr = $urandom; cycle();
        in_tag = 32'h402; instr = $urandom; cycle();
        in_tag = 32'h403; flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid32", 64'(out_valid32), 64'd0);
        chk("flush_out_valid64", 64'(out_valid64), 64'd0);
        chk("flush_in_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            immsrc    = 3'($urandom_range(0, 7));
            instr     = $urandom;
            in_tag    = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;

        // ---------------- illegal format and saturation ----------------
        out_ready = 1'b1; immsrc = 3'b111; ill_acc = 0;
        for (int i = 0; i < 400 && ill_acc < 300; i++) begin
            in_valid = 1'b1; instr = $urandom; in_tag = $urandom;
            acc = (mq.size() < 2);
            cycle();
            if (acc) ill_acc++;
        end
        in_valid = 1'b0;
        chk("ill_accepts", 64'(ill_acc), 64'd300);
        chk("ill_imm", 64'(immext32), 64'd0);
        chk("ill_err", 64'(out_err32), 64'd1);
        cycle();
        chk("err_sat32", 64'(err_count32), 64'd255);
        chk("err_sat64", 64'(err_count64), 64'd255);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0; in_valid = 1'b1; immsrc = 3'b100;
        in_tag = 32'h501; instr = $urandom; cycle();
        in_tag = 32'h502; instr = $urandom; cycle();
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        m_err_cnt = 0;
        check_reset_values("reset_mid");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;

        // ---------------- recovery traffic ----------------
        for (int i = 0; i < 20; i++) begin
            in_valid  = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            immsrc    = 3'($urandom_range(0, 7));
            instr     = $urandom;
            in_tag    = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
